// File: rtl/fifo_pkg.sv
// Shared async-FIFO constants and types.
// Default data/address widths plus the 2-bit skid occupancy type.
package fifo_pkg;

  localparam int DSIZE_DEF    = 8;
  localparam int ADDRSIZE_DEF = 4;

  typedef logic [1:0] ocnt_t;

  localparam ocnt_t OCNT_EMPTY = 2'd0;
  localparam ocnt_t OCNT_ONE   = 2'd1;
  localparam ocnt_t OCNT_FULL  = 2'd2;

endpackage

// File: rtl/fifo_rd_stream.sv
// Read-side stream stage: pops FIFO words into a 2-entry skid buffer.
// Ports: rclk/rrst_n, rempty/rdata/rinc (FIFO), m_* (stream), ocnt, xfer_cnt.
module fifo_rd_stream
  import fifo_pkg::*;
#(
  parameter int DSIZE = DSIZE_DEF,
  parameter int CNTW  = 16
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic             rempty,
  input  logic [DSIZE-1:0] rdata,
  output logic             rinc,
  output logic             m_valid,
  output logic [DSIZE-1:0] m_data,
  input  logic             m_ready,
  output ocnt_t            ocnt,
  output logic [CNTW-1:0]  xfer_cnt
);

  logic             armed_q;
  ocnt_t            ocnt_q, ocnt_d;
  logic [DSIZE-1:0] head_q, head_d;
  logic [DSIZE-1:0] skid_q, skid_d;
  logic [CNTW-1:0]  cnt_q, cnt_d;
  logic             push, pop;

  // armed masks the one-cycle false "not empty" the pointer
  // stage shows straight out of reset.
  assign rinc = armed_q & ~rempty & (ocnt_q != OCNT_FULL);

  assign push     = rinc;
  assign pop      = m_valid & m_ready;
  assign m_valid  = (ocnt_q != OCNT_EMPTY);
  assign m_data   = head_q;
  assign ocnt     = ocnt_q;
  assign xfer_cnt = cnt_q;

  always_comb begin
    head_d = head_q;
    skid_d = skid_q;
    ocnt_d = ocnt_q;
    case ({push, pop})
      2'b10: begin
        if (ocnt_q == OCNT_EMPTY) begin
          head_d = rdata;
          ocnt_d = OCNT_ONE;
        end else begin
          skid_d = rdata;
          ocnt_d = OCNT_FULL;
        end
      end
      2'b01: begin
        if (ocnt_q == OCNT_FULL) begin
          head_d = skid_q;
          ocnt_d = OCNT_ONE;
        end else begin
          ocnt_d = OCNT_EMPTY;
        end
      end
      // push never happens at full, so this is always ocnt 1
      2'b11: head_d = rdata;
      default: ;
    endcase
  end

  assign cnt_d = cnt_q + CNTW'(pop);

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      armed_q <= 1'b0;
      ocnt_q  <= OCNT_EMPTY;
      head_q  <= '0;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      armed_q <= 1'b1;
      ocnt_q  <= ocnt_d;
      head_q  <= head_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Scoreboard bench for fifo_rd_stream.
// Models the FIFO source, checks order, stability, pop guard and counters.
module tb_fifo_rd_stream;

  localparam int DW = 8;

  logic          rclk = 1'b0;
  logic          rrst_n;
  logic          rempty;
  logic [DW-1:0] rdata;
  logic          rinc;
  logic          m_valid;
  logic [DW-1:0] m_data;
  logic          m_ready;
  logic [1:0]    ocnt;
  logic [15:0]   xfer_cnt;

  logic          rinc_w;
  logic          m_valid_w;
  logic [DW-1:0] m_data_w;
  logic [1:0]    ocnt_w;
  logic [3:0]    xfer_w;

  fifo_rd_stream #(.DSIZE(DW), .CNTW(16)) u_dut (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc), .m_valid(m_valid), .m_data(m_data),
    .m_ready(m_ready), .ocnt(ocnt), .xfer_cnt(xfer_cnt)
  );

  fifo_rd_stream #(.DSIZE(DW), .CNTW(4)) u_wrap (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata),
    .rinc(rinc_w), .m_valid(m_valid_w), .m_data(m_data_w),
    .m_ready(m_ready), .ocnt(ocnt_w), .xfer_cnt(xfer_w)
  );

  always #5 rclk = ~rclk;

  int            n_checks = 0;
  int            n_fail   = 0;
  logic [DW-1:0] src_q[$];
  logic [DW-1:0] exp_q[$];
  int            dcyc[$];
  int            cyc = 0;
  logic          drv_en = 1'b0;
  logic          rnd_en = 1'b0;
  logic          saw_valid = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic upd_src(input logic gap);
    if (src_q.size() == 0) rempty = 1'b1;
    else begin
      rempty = gap;
      rdata  = src_q[0];
    end
  endtask

  task automatic load(input logic [DW-1:0] v);
    src_q.push_back(v);
    exp_q.push_back(v);
    upd_src(1'b0);
  endtask

  task automatic pre_edge();
    @(negedge rclk);
    #4;
  endtask

  task automatic wait_drain(input int bound);
    int n = 0;
    while (exp_q.size() != 0 && n < bound) begin
      @(posedge rclk);
      n++;
    end
    @(posedge rclk);
    #2;
    chk("drain", exp_q.size(), 0);
  endtask

  // FIFO source: a pop seen just before the edge consumes the head word.
  initial begin
    logic pend;
    forever begin
      @(negedge rclk);
      #4;
      pend = drv_en && rrst_n && rinc;
      @(posedge rclk);
      #1;
      if (drv_en) begin
        if (pend) begin
          if (src_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL src_underflow: pop with empty source");
          end else void'(src_q.pop_front());
        end
        upd_src(rnd_en && ($urandom_range(0, 2) == 0));
      end
    end
  end

  // Monitor: sampled just before each rising edge.
  initial begin
    logic          hold;
    logic [DW-1:0] hd;
    logic [DW-1:0] e;
    hold = 1'b0;
    hd   = '0;
    forever begin
      @(negedge rclk);
      #4;
      cyc++;
      if (!rrst_n) hold = 1'b0;
      else begin
        if (hold) chk("stable", {m_valid, m_data}, {1'b1, hd});
        if (rinc) chk("rinc_guard", {ocnt == 2'd2, rempty}, 0);
        if (m_valid) saw_valid = 1'b1;
        if (m_valid && m_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL extra_word: got %0h expected none", m_data);
          end else begin
            e = exp_q.pop_front();
            chk("order", m_data, e);
            dcyc.push_back(cyc);
          end
        end
        hold = m_valid && !m_ready;
        hd   = m_data;
      end
    end
  end

  task automatic post_reset_mask();
    @(negedge rclk);
    #1;
    rrst_n = 1'b1;
    #1;
    chk("mask_rinc_now", rinc, 0);
    saw_valid = 1'b0;
    #2;
    chk("mask_rinc_edge", rinc, 0);
    @(posedge rclk);
    #1;
    rempty = 1'b1;
    repeat (5) pre_edge();
    chk("mask_no_valid", saw_valid, 0);
    chk("mask_rinc_idle", rinc, 0);
  endtask

  initial begin
    int nr;
    int n;
    rrst_n  = 1'b0;
    rempty  = 1'b0;
    rdata   = 8'h5A;
    m_ready = 1'b0;
    #23;
    chk("rst_valid", m_valid, 0);
    chk("rst_ocnt", ocnt, 0);
    chk("rst_rinc", rinc, 0);
    chk("rst_xfer", xfer_cnt, 0);
    chk("rst_data", m_data, 0);

    post_reset_mask();

    // streaming 0x01..0x10
    @(negedge rclk);
    #1;
    m_ready = 1'b1;
    dcyc.delete();
    drv_en = 1'b1;
    for (int i = 1; i <= 16; i++) load(DW'(i));
    #3;
    chk("stream_rinc", rinc, 1);
    pre_edge();
    chk("stream_latency", {m_valid, m_data}, 9'h101);
    wait_drain(100);
    chk("stream_count", dcyc.size(), 16);
    if (dcyc.size() == 16)
      chk("stream_span", dcyc[15] - dcyc[0], 15);
    chk("stream_xfer", xfer_cnt, 16);
    chk("wrap_16", xfer_w, 0);

    // backpressure
    @(negedge rclk);
    #1;
    m_ready = 1'b0;
    dcyc.delete();
    for (int i = 1; i <= 4; i++) load(DW'(i));
    #3;
    nr = 0;
    for (int k = 0; k < 5; k++) begin
      if (rinc) nr++;
      if (k < 4) pre_edge();
    end
    chk("bp_rinc_cnt", nr, 2);
    chk("bp_ocnt", ocnt, 2);
    chk("bp_head", {m_valid, m_data}, 9'h101);
    @(negedge rclk);
    #1;
    m_ready = 1'b1;
    #3;
    chk("bp_rinc_held", rinc, 0);
    pre_edge();
    chk("bp_rinc_back", rinc, 1);
    wait_drain(100);
    chk("bp_count", dcyc.size(), 4);
    if (dcyc.size() == 4)
      chk("bp_span", dcyc[3] - dcyc[0], 3);
    chk("bp_xfer", xfer_cnt, 20);
    chk("wrap_20", xfer_w, 4);

    // random gaps and backpressure, 1000 words
    @(negedge rclk);
    #1;
    rnd_en = 1'b1;
    for (int i = 0; i < 1000; i++) load(DW'($urandom_range(0, 255)));
    n = 0;
    while (exp_q.size() != 0 && n < 20000) begin
      @(negedge rclk);
      #1;
      m_ready = 1'($urandom_range(0, 1));
      n++;
    end
    rnd_en = 1'b0;
    @(posedge rclk);
    #2;
    chk("rnd_drain", exp_q.size(), 0);
    chk("rnd_xfer", xfer_cnt, 1020);
    chk("wrap_1020", xfer_w, 12);

    // reset with the skid full
    @(negedge rclk);
    #1;
    m_ready = 1'b0;
    load(8'hA1);
    load(8'hA2);
    load(8'hA3);
    repeat (3) pre_edge();
    chk("mid_ocnt", ocnt, 2);
    @(negedge rclk);
    #2;
    rrst_n = 1'b0;
    drv_en = 1'b0;
    src_q.delete();
    exp_q.delete();
    rempty = 1'b0;
    #1;
    chk("mid_valid", m_valid, 0);
    chk("mid_ocnt0", ocnt, 0);
    chk("mid_rinc", rinc, 0);
    chk("mid_xfer", xfer_cnt, 0);
    chk("mid_wrap", xfer_w, 0);
    post_reset_mask();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
